// File: rtl/pattern_gen.sv
// Display test-pattern generator: delays sync/DE by one dot clock and paints
// colour bars, checkerboard, grey ramp or a moving box, latched per frame.
module pattern_gen #(
    parameter int unsigned BOX   = 64,
    parameter int unsigned HSTEP = 4,
    parameter int unsigned VSTEP = 2
) (
    input  logic       DCLK,
    input  logic       DRST,
    input  logic [1:0] RESOL,
    input  logic [1:0] PATSEL,
    input  logic       HSYNC_X_IN,
    input  logic       VSYNC_X_IN,
    input  logic       PRE_DE,
    output logic       DSP_HSYNC_X,
    output logic       DSP_VSYNC_X,
    output logic       DSP_DE,
    output logic [7:0] DSP_R,
    output logic [7:0] DSP_G,
    output logic [7:0] DSP_B
);

    localparam logic [10:0] BoxW  = 11'(BOX);
    localparam logic [10:0] HStep = 11'(HSTEP);
    localparam logic [10:0] VStep = 11'(VSTEP);

    function automatic logic [10:0] hdo_of(input logic [1:0] r);
        logic [10:0] v;
        case (r)
            2'b00:   v = 11'd640;
            2'b01:   v = 11'd800;
            2'b10:   v = 11'd1024;
            default: v = 11'd1280;
        endcase
        return v;
    endfunction

    function automatic logic [10:0] vdo_of(input logic [1:0] r);
        logic [10:0] v;
        case (r)
            2'b00:   v = 11'd480;
            2'b01:   v = 11'd600;
            2'b10:   v = 11'd768;
            default: v = 11'd1024;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] barw_of(input logic [1:0] r);
        logic [7:0] v;
        case (r)
            2'b00:   v = 8'd80;
            2'b01:   v = 8'd100;
            2'b10:   v = 8'd128;
            default: v = 8'd160;
        endcase
        return v;
    endfunction

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] v;
        case (idx)
            3'd0:    v = 24'hFFFFFF;
            3'd1:    v = 24'hFFFF00;
            3'd2:    v = 24'h00FFFF;
            3'd3:    v = 24'h00FF00;
            3'd4:    v = 24'hFF00FF;
            3'd5:    v = 24'hFF0000;
            3'd6:    v = 24'h0000FF;
            default: v = 24'h000000;
        endcase
        return v;
    endfunction

    logic        vs_q;
    logic        de_q;
    logic        hs_q;
    logic [1:0]  pat_q;
    logic [1:0]  res_q;
    logic [10:0] xcnt_q, xcnt_d;
    logic [10:0] ycnt_q, ycnt_d;
    logic [10:0] bx_q, bx_d;
    logic [10:0] by_q, by_d;
    logic [7:0]  bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [23:0] rgb_q, pix;
    logic        fs;
    logic        in_box;

    assign fs = vs_q & ~VSYNC_X_IN;

    // Counters: x and bar tracking reset during blanking, y steps at end of line.
    always_comb begin
        xcnt_d    = PRE_DE ? xcnt_q + 11'd1 : 11'd0;
        bar_cnt_d = 8'd0;
        bar_idx_d = 3'd0;
        if (PRE_DE) begin
            if (bar_cnt_q == barw_of(res_q) - 8'd1) begin
                bar_cnt_d = 8'd0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 8'd1;
                bar_idx_d = bar_idx_q;
            end
        end
        ycnt_d = ycnt_q;
        if (fs) begin
            ycnt_d = 11'd0;
        end else if (de_q && !PRE_DE) begin
            ycnt_d = ycnt_q + 11'd1;
        end
    end

    // Box advances at frame start against the resolution being latched now.
    always_comb begin
        bx_d = bx_q;
        by_d = by_q;
        if (fs) begin
            bx_d = (bx_q + HStep > hdo_of(RESOL) - BoxW) ? 11'd0 : bx_q + HStep;
            by_d = (by_q + VStep > vdo_of(RESOL) - BoxW) ? 11'd0 : by_q + VStep;
        end
    end

    always_comb begin
        in_box = (xcnt_q >= bx_q) && (xcnt_q < bx_q + BoxW) &&
                 (ycnt_q >= by_q) && (ycnt_q < by_q + BoxW);
        pix = 24'h000000;
        if (PRE_DE) begin
            unique case (pat_q)
                2'b00: pix = bar_rgb(bar_idx_q);
                2'b01: pix = (xcnt_q[5] ^ ycnt_q[5]) ? 24'h000000 : 24'hFFFFFF;
                2'b10: pix = {xcnt_q[7:0], xcnt_q[7:0], xcnt_q[7:0]};
                2'b11: pix = in_box ? 24'hFFFFFF : 24'h0000FF;
            endcase
        end
    end

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            vs_q      <= 1'b1;
            hs_q      <= 1'b1;
            de_q      <= 1'b0;
            rgb_q     <= 24'h000000;
            pat_q     <= 2'b00;
            res_q     <= 2'b00;
            xcnt_q    <= 11'd0;
            ycnt_q    <= 11'd0;
            bx_q      <= 11'd0;
            by_q      <= 11'd0;
            bar_cnt_q <= 8'd0;
            bar_idx_q <= 3'd0;
        end else begin
            vs_q      <= VSYNC_X_IN;
            hs_q      <= HSYNC_X_IN;
            de_q      <= PRE_DE;
            rgb_q     <= pix;
            if (fs) begin
                pat_q <= PATSEL;
                res_q <= RESOL;
            end
            xcnt_q    <= xcnt_d;
            ycnt_q    <= ycnt_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    // The VSYNC history register doubles as the delayed output.
    assign DSP_HSYNC_X = hs_q;
    assign DSP_VSYNC_X = vs_q;
    assign DSP_DE      = de_q;
    assign DSP_R       = rgb_q[23:16];
    assign DSP_G       = rgb_q[15:8];
    assign DSP_B       = rgb_q[7:0];

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: a behavioural model queues each cycle's
// expected outputs, plus fixed reference pixels checked on the way out.
module tb_pattern_gen;

    localparam int BOX   = 64;
    localparam int HSTEP = 4;
    localparam int VSTEP = 2;

    logic       DCLK = 1'b0;
    logic       DRST;
    logic [1:0] RESOL;
    logic [1:0] PATSEL;
    logic       HSYNC_X_IN;
    logic       VSYNC_X_IN;
    logic       PRE_DE;
    logic       DSP_HSYNC_X;
    logic       DSP_VSYNC_X;
    logic       DSP_DE;
    logic [7:0] DSP_R;
    logic [7:0] DSP_G;
    logic [7:0] DSP_B;

    pattern_gen #(.BOX(BOX), .HSTEP(HSTEP), .VSTEP(VSTEP)) dut (
        .DCLK        (DCLK),
        .DRST        (DRST),
        .RESOL       (RESOL),
        .PATSEL      (PATSEL),
        .HSYNC_X_IN  (HSYNC_X_IN),
        .VSYNC_X_IN  (VSYNC_X_IN),
        .PRE_DE      (PRE_DE),
        .DSP_HSYNC_X (DSP_HSYNC_X),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .DSP_DE      (DSP_DE),
        .DSP_R       (DSP_R),
        .DSP_G       (DSP_G),
        .DSP_B       (DSP_B)
    );

    always #5 DCLK = ~DCLK;

    typedef struct {
        logic [26:0] exp;
        int          pat;
        int          res;
        int          frame;
        int          x;
        int          y;
        bit          de;
    } sb_t;

    typedef struct {
        int          pat;
        int          res;
        int          frame;
        int          x;
        int          y;
        logic [23:0] rgb;
    } spot_t;

    sb_t   sb_q[$];
    spot_t spots[$];

    int          hdo_t[4] = '{640, 800, 1024, 1280};
    int          vdo_t[4] = '{480, 600, 768, 1024};
    logic [23:0] bar_t[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int m_pat, m_res, m_x, m_y, m_bx, m_by, m_frame;
    bit m_vs_prev, m_de_prev;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_rgb(int pat, int res, int x, int y, int bx, int by);
        logic [7:0] g;
        case (pat)
            0: return bar_t[x / (hdo_t[res] / 8)];
            1: return (((x / 32) + (y / 32)) % 2 == 1) ? 24'h000000 : 24'hFFFFFF;
            2: begin
                g = 8'(x % 256);
                return {g, g, g};
            end
            default: return (x >= bx && x < bx + BOX && y >= by && y < by + BOX) ?
                            24'hFFFFFF : 24'h0000FF;
        endcase
    endfunction

    task automatic model_reset();
        m_pat = 0; m_res = 0; m_x = 0; m_y = 0; m_bx = 0; m_by = 0; m_frame = 0;
        m_vs_prev = 1'b1; m_de_prev = 1'b0;
    endtask

    task automatic drive(input bit rst, input bit hs, input bit vs, input bit de);
        sb_t         e;
        logic [26:0] got;
        DRST = rst; HSYNC_X_IN = hs; VSYNC_X_IN = vs; PRE_DE = de;
        e.pat = m_pat; e.res = m_res; e.frame = m_frame; e.x = m_x; e.y = m_y;
        e.de  = !rst && de;
        if (rst) begin
            e.exp = {1'b1, 1'b1, 1'b0, 24'h000000};
            model_reset();
        end else begin
            e.exp = {hs, vs, de, de ? model_rgb(m_pat, m_res, m_x, m_y, m_bx, m_by) : 24'h0};
            if (!vs && m_vs_prev) begin
                m_pat = int'(PATSEL);
                m_res = int'(RESOL);
                m_y   = 0;
                m_frame++;
                m_bx  = (m_bx + HSTEP > hdo_t[m_res] - BOX) ? 0 : m_bx + HSTEP;
                m_by  = (m_by + VSTEP > vdo_t[m_res] - BOX) ? 0 : m_by + VSTEP;
            end else if (m_de_prev && !de) begin
                m_y++;
            end
            m_x       = de ? m_x + 1 : 0;
            m_de_prev = de;
            m_vs_prev = vs;
        end
        sb_q.push_back(e);
        @(posedge DCLK);
        #1;
        check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, DSP_R, DSP_G, DSP_B};
            check_eq($sformatf("out p%0d x%0d y%0d", e.pat, e.x, e.y), 32'(got), 32'(e.exp));
            if (e.de) begin
                foreach (spots[i]) begin
                    if (spots[i].pat == e.pat && spots[i].res == e.res && spots[i].x == e.x &&
                        (spots[i].frame < 0 || spots[i].frame == e.frame) &&
                        (spots[i].y < 0 || spots[i].y == e.y)) begin
                        check_eq($sformatf("spot p%0d f%0d (%0d,%0d)", e.pat, e.frame, e.x, e.y),
                                 32'(got[23:0]), 32'(spots[i].rgb));
                    end
                end
            end
        end
    endtask

    task automatic vframe();
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
    endtask

    task automatic hline(input int n);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 1, 1, 0);
        for (int i = 0; i < n; i++) drive(0, 1, 1, 1);
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
    endtask

    initial begin
        RESOL = 2'b00; PATSEL = 2'b00;
        DRST = 1'b1; HSYNC_X_IN = 1'b1; VSYNC_X_IN = 1'b1; PRE_DE = 1'b0;
        model_reset();

        spots.push_back('{0, 0, -1, 0,   -1, 24'hFFFFFF});
        spots.push_back('{0, 0, -1, 79,  -1, 24'hFFFFFF});
        spots.push_back('{0, 0, -1, 80,  -1, 24'hFFFF00});
        spots.push_back('{0, 0, -1, 560, -1, 24'h000000});
        spots.push_back('{0, 0, -1, 639, -1, 24'h000000});
        spots.push_back('{1, 0, -1, 0,   0,  24'hFFFFFF});
        spots.push_back('{1, 0, -1, 32,  0,  24'h000000});
        spots.push_back('{1, 0, -1, 0,   32, 24'h000000});
        spots.push_back('{1, 0, -1, 32,  32, 24'hFFFFFF});
        spots.push_back('{2, 1, -1, 255, -1, 24'hFFFFFF});
        spots.push_back('{2, 1, -1, 300, -1, 24'h2C2C2C});
        spots.push_back('{2, 1, -1, 799, -1, 24'h1F1F1F});
        spots.push_back('{3, 0, 1,   4,  2,   24'hFFFFFF});
        spots.push_back('{3, 0, 1,   3,  2,   24'h0000FF});
        spots.push_back('{3, 0, 1,   67, 2,   24'hFFFFFF});
        spots.push_back('{3, 0, 1,   68, 2,   24'h0000FF});
        spots.push_back('{3, 0, 145, 0,  290, 24'hFFFFFF});
        spots.push_back('{3, 0, 145, 63, 290, 24'hFFFFFF});
        spots.push_back('{3, 0, 145, 64, 290, 24'h0000FF});
        spots.push_back('{3, 0, 145, 0,  289, 24'h0000FF});

        // Reset held with PRE_DE toggling, then normal operation.
        for (int i = 0; i < 3; i++) drive(1, 1, 1, (i % 2) == 1);

        vframe();
        hline(640);
        PATSEL = 2'b01;
        hline(640);
        hline(640);

        vframe();
        for (int i = 0; i < 33; i++) hline(40);

        PATSEL = 2'b10; RESOL = 2'b01;
        vframe();
        hline(800);

        // Reset in the middle of an active line.
        drive(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 1, 1);
        drive(1, 1, 1, 1);
        drive(1, 1, 1, 1);
        drive(0, 1, 1, 1);
        drive(0, 1, 1, 0);

        PATSEL = 2'b11; RESOL = 2'b00;
        vframe();
        for (int i = 0; i < 4; i++) hline(70);
        for (int f = 0; f < 144; f++) vframe();
        for (int i = 0; i < 292; i++) hline(70);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Display test-pattern generator sitting directly downstream of the sync generator. It consumes the generator's sync and pre-data-enable outputs and produces one-cycle-delayed, pixel-aligned HSYNC/VSYNC/DE together with 24-bit RGB for the display output stage. Four selectable patterns are supported: colour bars, checkerboard, grey ramp and moving box. Pattern and resolution are latched once per frame so a frame never tears.

## Interface
Parameters:
- BOX, 64, moving-box edge length in pixels (power of two).
- HSTEP, 4, box horizontal advance per frame (pixels).
- VSTEP, 2, box vertical advance per frame (lines).

Ports:
- DCLK  in  1  dot clock; all logic on rising edge.
- DRST  in  1  reset, synchronous, active-high.
- RESOL  in  2  resolution: 00 640x480, 01 800x600, 10 1024x768, 11 1280x1024.
- PATSEL  in  2  pattern: 00 colour bars, 01 checkerboard, 10 grey ramp, 11 moving box.
- HSYNC_X_IN  in  1  horizontal sync from sync generator, active-low.
- VSYNC_X_IN  in  1  vertical sync from sync generator, active-low.
- PRE_DE  in  1  data enable, one cycle early, from sync generator.
- DSP_HSYNC_X  out  1  HSYNC_X_IN delayed 1 cycle.
- DSP_VSYNC_X  out  1  VSYNC_X_IN delayed 1 cycle.
- DSP_DE  out  1  PRE_DE delayed 1 cycle.
- DSP_R, DSP_G, DSP_B  out  8 each  pixel colour, valid when DSP_DE=1, 0 otherwise.

## Operation
- Frame start (FS): cycle where VSYNC_X_IN=0 and its registered previous value=1. At FS: PAT<=PATSEL, RES<=RESOL, YCNT<=0, box position updates. Between FS events PATSEL/RESOL changes are ignored.
- HDO/VDO: active width/height decoded from RES (640/480, 800/600, 1024/768, 1280/1024).
- XCNT (11 b): 0 while PRE_DE=0; +1 each PRE_DE=1 cycle. Pixel at cycle t uses current XCNT (first pixel x=0).
- YCNT (11 b): +1 on PRE_DE falling edge (1->0); cleared at FS (FS wins if simultaneous).
- Colour bars: 8 bars of width HDO/8 (80/100/128/160), tracked with a within-bar counter and 3-bit bar index (no divider), both cleared when PRE_DE=0. Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Checkerboard: XCNT[5]^YCNT[5] = 0 -> FFFFFF, else 000000 (32x32 cells).
- Grey ramp: R=G=B=XCNT[7:0] (wraps every 256 pixels).
- Moving box: BX, BY (11 b). At FS: BX <= (BX+HSTEP > HDO-BOX) ? 0 : BX+HSTEP; BY likewise with VSTEP/VDO. Pixel inside [BX, BX+BOX-1] x [BY, BY+BOX-1] -> FFFFFF, else background 0000FF. Update uses the newly latched RES.
- RGB forced to 0 whenever PRE_DE=0 at the computing cycle.

## Timing
- Latency: exactly 1 DCLK from inputs to all outputs; DSP_DE and RGB of pixel x emerge on the same cycle.
- Reset values: DSP_HSYNC_X=1, DSP_VSYNC_X=1, DSP_DE=0, RGB=0, XCNT=YCNT=0, BX=BY=0, PAT=00, RES=00, VSYNC history=1.
- Reset mid-line/mid-frame: outputs return to reset values on the next edge; first FS after release re-latches PAT/RES. Box restarts from (0,0) and first moves at that FS.
- No backpressure; block accepts one pixel per cycle unconditionally.

## Test plan
- Reset: hold DRST 3 cycles with PRE_DE toggling -> DSP_DE=0, RGB=000000, syncs=1 throughout; all one cycle after release still follow 1-cycle latency.
- Colour bars, RESOL=00: active line -> DSP_DE high 640 cycles; x=0 FFFFFF, x=79 FFFFFF, x=80 FFFF00, x=560 000000, x=639 000000; DE rises 1 cycle after PRE_DE.
- Checkerboard line 0 and line 32: (0,0) FFFFFF, (32,0) 000000, (0,32) 000000, (32,32) FFFFFF.
- Grey ramp, RESOL=01: x=255 -> FF/FF/FF, x=300 -> 2C/2C/2C, x=799 -> 1F/1F/1F.
- Moving box, RESOL=00: frame 1 box at BX=4,BY=2 (pixel (4,2) FFFFFF, (3,2) 0000FF, (68,2) 0000FF); after 145 frames BX=0 (wrapped from 576).
- PATSEL changed from 00 to 01 mid-frame -> remainder of frame stays colour bars; checkerboard from next FS.
